// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg: shared state encoding and counter-width helper for the PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        PLL_RESET = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic two-flop synchronizer for W asynchronous bits, asynchronous active-high reset.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= '0;
            q_o    <= '0;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences PLL reset, waits for a stable lock, then releases the system reset.
// Optional lock-loss glitch filter enabled by defining PLL_LOCK_SUPERVISOR_GLITCH_FILTER_EN.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3,
    parameter int GLITCH_CYCLES = 4
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       sw_relock_req,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       lock_stable,
    output logic       relock_fail,
    output logic [7:0] lock_loss_cnt,
`ifdef PLL_LOCK_SUPERVISOR_GLITCH_FILTER_EN
    output logic [2:0] glitch_cnt,
`endif
    output logic [2:0] state_o
);

    // In RUN the shared counter tracks the current run of low lock samples.
    localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT,
                                  (STABLE_CYCLES > GLITCH_CYCLES) ? STABLE_CYCLES : GLITCH_CYCLES);
    localparam int RW = cnt_width(MAX_RETRIES + 1, 1, 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, run_cnt;
    logic [RW-1:0] retry_q, retry_d;
    logic [7:0]    loss_q, loss_d;
    logic          pll_rst_q, sys_rst_q, lock_stable_q, relock_fail_q;
    logic          locked_s, loss_evt;

    sync_2ff #(.W(1)) u_sync (
        .clk_i (refclk),
        .rst_i (rst),
        .d_i   (pll_locked),
        .q_o   (locked_s)
    );

`ifdef PLL_LOCK_SUPERVISOR_GLITCH_FILTER_EN
    logic [2:0] glitch_q, glitch_d;

    assign loss_evt = !locked_s && cnt_q == CW'(GLITCH_CYCLES - 1);
    assign run_cnt  = locked_s ? '0 : cnt_q + CW'(1);
    assign glitch_d = (state_q == RUN && locked_s && cnt_q != '0 && glitch_q != 3'd7) ?
                      glitch_q + 3'd1 : glitch_q;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) glitch_q <= '0;
        else     glitch_q <= glitch_d;
    end

    assign glitch_cnt = glitch_q;
`else
    assign loss_evt = !locked_s;
    assign run_cnt  = '0;
`endif

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        unique case (state_q)
            PLL_RESET: if (cnt_q == CW'(RST_CYCLES - 1)) state_d = WAIT_LOCK;
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = STABILIZE;
                end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                    if (retry_q < RW'(MAX_RETRIES)) begin
                        retry_d = retry_q + RW'(1);
                        state_d = PLL_RESET;
                    end else begin
                        state_d = FAIL;
                    end
                end
            end
            STABILIZE: begin
                if (!locked_s) state_d = WAIT_LOCK;
                else if (cnt_q == CW'(STABLE_CYCLES - 1)) state_d = RUN;
            end
            RUN: begin
                retry_d = '0;
                if (loss_evt) begin
                    state_d = PLL_RESET;
                    loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
                end
            end
            FAIL: state_d = FAIL;
            default: state_d = PLL_RESET;
        endcase
        // A software request overrides everything, including a same-cycle lock loss.
        if (sw_relock_req) begin
            state_d = PLL_RESET;
            retry_d = '0;
            loss_d  = loss_q;
        end
        cnt_d = (state_d != state_q || sw_relock_req) ? '0 :
                (state_q == RUN)  ? run_cnt :
                (state_q == FAIL) ? cnt_q : cnt_q + CW'(1);
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q       <= PLL_RESET;
            cnt_q         <= '0;
            retry_q       <= '0;
            loss_q        <= '0;
            pll_rst_q     <= 1'b1;
            sys_rst_q     <= 1'b1;
            lock_stable_q <= 1'b0;
            relock_fail_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            loss_q        <= loss_d;
            pll_rst_q     <= state_d == PLL_RESET;
            sys_rst_q     <= state_d != RUN;
            lock_stable_q <= state_d == RUN;
            relock_fail_q <= state_d == FAIL;
        end
    end

    assign pll_rst       = pll_rst_q;
    assign sys_rst       = sys_rst_q;
    assign lock_stable   = lock_stable_q;
    assign relock_fail   = relock_fail_q;
    assign lock_loss_cnt = loss_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: directed and randomized checks of the PLL lock supervisor against a cycle model.
module tb_pll_lock_supervisor;
    import pll_sup_pkg::*;

    localparam int RSTC = 4, TO = 20, STB = 8, MR = 2, GL = 4;
`ifdef PLL_LOCK_SUPERVISOR_GLITCH_FILTER_EN
    localparam int DROP = GL, T3_LOSS = 0;
`else
    localparam int DROP = 1, T3_LOSS = 1;
`endif

    logic       refclk = 1'b0, rst = 1'b1, pll_locked = 1'b0, sw_relock_req = 1'b0;
    logic       pll_rst, sys_rst, lock_stable, relock_fail;
    logic [7:0] lock_loss_cnt;
    logic [2:0] state_o;
`ifdef PLL_LOCK_SUPERVISOR_GLITCH_FILTER_EN
    logic [2:0] glitch_cnt;
`endif
    int tests = 0, fails = 0;
    bit chk_en = 1'b0;

    pll_lock_supervisor #(
        .RST_CYCLES(RSTC), .LOCK_TIMEOUT(TO), .STABLE_CYCLES(STB),
        .MAX_RETRIES(MR), .GLITCH_CYCLES(GL)
    ) dut (
        .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .sw_relock_req(sw_relock_req),
        .pll_rst(pll_rst), .sys_rst(sys_rst), .lock_stable(lock_stable),
        .relock_fail(relock_fail), .lock_loss_cnt(lock_loss_cnt),
`ifdef PLL_LOCK_SUPERVISOR_GLITCH_FILTER_EN
        .glitch_cnt(glitch_cnt),
`endif
        .state_o(state_o)
    );

    always #5 refclk = ~refclk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge refclk);
    endtask

    task automatic wait_state(input state_t s, input int lim, input string nm);
        int i;
        i = 0;
        while (state_o !== s && i < lim) begin
            @(negedge refclk);
            i++;
        end
        check(nm, state_o, s);
    endtask

    // Reference model: age = cycles spent in the current state, lock seen two edges late.
    state_t     m_st = PLL_RESET;
    int         m_age = 0, m_tries = 0, m_loss = 0, m_low = 0, m_glitch = 0;
    logic [1:0] m_sh = 2'b00;

    initial begin : model
        state_t nxt;
        logic   ls, loss;
        forever begin
            @(posedge refclk or posedge rst);
            if (rst) begin
                m_st = PLL_RESET; m_age = 0; m_tries = 0; m_loss = 0;
                m_low = 0; m_glitch = 0; m_sh = 2'b00;
            end else begin
                ls   = m_sh[1];
                m_sh = {m_sh[0], pll_locked};
                nxt  = m_st;
                loss = 1'b0;
                case (m_st)
                    PLL_RESET: if (m_age + 1 >= RSTC) nxt = WAIT_LOCK;
                    WAIT_LOCK: begin
                        if (ls) nxt = STABILIZE;
                        else if (m_age + 1 >= TO) begin
                            if (m_tries < MR) begin m_tries++; nxt = PLL_RESET; end
                            else nxt = FAIL;
                        end
                    end
                    STABILIZE: begin
                        if (!ls) nxt = WAIT_LOCK;
                        else if (m_age + 1 >= STB) nxt = RUN;
                    end
                    RUN: begin
                        m_tries = 0;
`ifdef PLL_LOCK_SUPERVISOR_GLITCH_FILTER_EN
                        if (ls && m_low > 0 && m_glitch < 7) m_glitch++;
                        m_low = ls ? 0 : m_low + 1;
                        loss  = m_low >= GL;
`else
                        loss = !ls;
`endif
                        if (loss) nxt = PLL_RESET;
                    end
                    default: ;
                endcase
                if (sw_relock_req) begin
                    nxt = PLL_RESET;
                    m_tries = 0;
                end else if (loss && m_loss < 255) begin
                    m_loss++;
                end
                m_age = (nxt != m_st || sw_relock_req) ? 0 : m_age + 1;
                if (nxt != RUN) m_low = 0;
                m_st = nxt;
            end
        end
    end

    initial begin : compare
        logic [31:0] act, exp;
        forever begin
            @(negedge refclk);
            if (chk_en) begin
                act = {17'd0, state_o, pll_rst, sys_rst, lock_stable, relock_fail, lock_loss_cnt};
                exp = {17'd0, 3'(m_st), m_st == PLL_RESET, m_st != RUN, m_st == RUN,
                       m_st == FAIL, 8'(m_loss)};
`ifdef PLL_LOCK_SUPERVISOR_GLITCH_FILTER_EN
                act = (act << 3) | 32'(glitch_cnt);
                exp = (exp << 3) | 32'(m_glitch);
`endif
                check("outputs_vs_model", act, exp);
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : stim
        int   hi, n, rises, r1, r2, fail_at, pct;
        logic prev;
        cyc(3);
        chk_en = 1'b1;
        check("rst_pll_rst", pll_rst, 1);
        check("rst_sys_rst", sys_rst, 1);
        check("rst_lock_stable", lock_stable, 0);
        check("rst_relock_fail", relock_fail, 0);
        check("rst_loss_cnt", lock_loss_cnt, 0);
        check("rst_state", state_o, PLL_RESET);

        // First lock after reset
        rst = 1'b0;
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            if (pll_rst) hi++;
            cyc(1);
        end
        check("t1_pll_rst_cycles", hi, RSTC);
        pll_locked = 1'b1;
        n = 0;
        do begin
            @(posedge refclk);
            #1;
            n++;
        end while (sys_rst !== 1'b0 && n < 100);
        check("t1_sys_rst_latency", n, STB + 3);
        check("t1_lock_stable", lock_stable, 1);
        cyc(1);

        // One-cycle lock drop in RUN
        pll_locked = 1'b0;
        cyc(1);
        pll_locked = 1'b1;
`ifdef PLL_LOCK_SUPERVISOR_GLITCH_FILTER_EN
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            if (sys_rst) hi++;
            cyc(1);
        end
        check("t3_glitch_no_reset", hi, 0);
        check("t3_glitch_cnt", glitch_cnt, 1);
`else
        n = 1;
        while (sys_rst !== 1'b1 && n < 10) begin
            @(posedge refclk);
            #1;
            n++;
        end
        check("t3_loss_latency", n, 3);
        cyc(1);
        check("t3_loss_cnt", lock_loss_cnt, 1);
        check("t3_pll_rst", pll_rst, 1);
`endif

        // Lock drop during STABILIZE restarts the stabilization window
        sw_relock_req = 1'b1;
        cyc(1);
        sw_relock_req = 1'b0;
        wait_state(STABILIZE, 50, "t4_enter_stab");
        cyc(3);
        pll_locked = 1'b0;
        cyc(1);
        pll_locked = 1'b1;
        wait_state(WAIT_LOCK, 10, "t4_back_to_wait");
        check("t4_sys_rst_held", sys_rst, 1);
        wait_state(STABILIZE, 20, "t4_reenter_stab");
        n = 0;
        while (state_o === STABILIZE && n < 50) begin
            n++;
            cyc(1);
        end
        check("t4_stab_cycles", n, STB);
        check("t4_run", state_o, RUN);

        // Software request in the same cycle as a lock-loss event
        pll_locked = 1'b0;
        cyc(DROP + 1);
        sw_relock_req = 1'b1;
        cyc(1);
        sw_relock_req = 1'b0;
        pll_locked = 1'b1;
        check("sim_state", state_o, PLL_RESET);
        check("sim_loss_cnt", lock_loss_cnt, T3_LOSS);

        // Saturate the lock-loss counter
        for (int k = 0; k < 260; k++) begin
            n = 0;
            while (state_o !== RUN && n < 200) begin
                cyc(1);
                n++;
            end
            if (n == 200) begin
                check("t5_reach_run", state_o, RUN);
                break;
            end
            pll_locked = 1'b0;
            cyc(DROP);
            pll_locked = 1'b1;
            cyc(3);
        end
        check("t5_loss_sat", lock_loss_cnt, 255);

        // Randomized lock behaviour with occasional software requests
        for (int seg = 0; seg < 4; seg++) begin
            pct = (seg == 0) ? 2 : (seg == 1) ? 10 : (seg == 2) ? 30 : 1;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(99) < pct) pll_locked = ~pll_locked;
                sw_relock_req = ($urandom_range(149) == 0);
                cyc(1);
            end
        end
        sw_relock_req = 1'b0;

        // Lock never arrives: bounded retries then FAIL
        #2 rst = 1'b1;
        pll_locked = 1'b0;
        cyc(2);
        rst = 1'b0;
        hi = 0; rises = 0; r1 = 0; r2 = 0; fail_at = -1; prev = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (pll_rst && !prev) begin
                if (rises == 1) r1 = i;
                if (rises == 2) r2 = i;
                rises++;
            end
            prev = pll_rst;
            if (pll_rst) hi++;
            if (relock_fail && fail_at < 0) fail_at = i;
            cyc(1);
        end
        check("t2_pulses", rises, MR + 1);
        check("t2_pulse2_start", r1, RSTC + TO);
        check("t2_pulse3_start", r2, 2 * (RSTC + TO));
        check("t2_pll_rst_total", hi, (MR + 1) * RSTC);
        check("t2_fail_at", fail_at, 3 * (RSTC + TO));
        check("t2_sys_rst", sys_rst, 1);
        sw_relock_req = 1'b1;
        cyc(1);
        sw_relock_req = 1'b0;
        check("t2_req_state", state_o, PLL_RESET);
        check("t2_req_relock_fail", relock_fail, 0);

        // Asynchronous reset in the middle of STABILIZE
        pll_locked = 1'b1;
        wait_state(STABILIZE, 50, "t6_enter_stab");
        cyc(2);
        @(posedge refclk);
        #3 rst = 1'b1;
        #1;
        check("t6_pll_rst", pll_rst, 1);
        check("t6_sys_rst", sys_rst, 1);
        check("t6_lock_stable", lock_stable, 0);
        check("t6_relock_fail", relock_fail, 0);
        check("t6_loss_cnt", lock_loss_cnt, 0);
        check("t6_state", state_o, PLL_RESET);
        cyc(2);
        rst = 1'b0;
        cyc(5);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
